fuel_refill_controller: RTL and testbench

Sequential refuelling engine. It is the fill-side counterpart to the fuel gauge, which only drains and monitors the tank. It accepts a refill request over a valid/ready handshake and meters fuel into the tank one unit per PUMP_DIV clocks. Filling saturates at tank capacity and can be aborted. The resulting fuel_level is the value the gauge path consumes as its input_fuel.

---
 rtl/fuel_refill_controller.sv | 145 ++++++++++++++
 tb/tb_fuel_refill_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fuel_refill_controller.sv
// Refuelling engine: accepts a refill request over valid/ready, meters fuel
// into the tank one unit every PUMP_DIV clocks, saturates at CAPACITY and
// supports abort. fuel_level feeds the gauge path as its input fuel.
module fuel_refill_controller #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CAPACITY = 31,
  parameter int unsigned PUMP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tank_level,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_amount,
  input  logic             abort,
  output logic             req_ready,
  output logic             pump_en,
  output logic [WIDTH-1:0] fuel_level,
  output logic [WIDTH-1:0] delivered,
  output logic             done,
  output logic             capped,
  output logic             aborted
);

  localparam int unsigned     CW       = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(PUMP_DIV - 1);
  localparam logic [WIDTH:0]  CAP_EXT  = (WIDTH + 1)'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUMP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_fuel;
  logic [WIDTH-1:0] r_deliv;
  logic [WIDTH-1:0] r_target;
  logic             r_capped;
  logic             r_aborted;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_target;
  logic             w_capped;
  logic             w_accept;
  logic             w_unit;

  // Request evaluation: fill target clamped to capacity; an overfull tank is
  // treated as already full so the target never drops below the tank level.
  always_comb begin
    w_sum = {1'b0, tank_level} + {1'b0, req_amount};
    if ({1'b0, tank_level} > CAP_EXT) begin
      w_target = tank_level;
    end else if (w_sum > CAP_EXT) begin
      w_target = WIDTH'(CAPACITY);
    end else begin
      w_target = w_sum[WIDTH-1:0];
    end
    w_capped = (w_sum > CAP_EXT) && (req_amount != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs; abort takes priority over a unit
  // completing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    pump_en     = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_unit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_target == tank_level) ? S_DONE : S_PUMP;
        end
      end
      S_PUMP: begin
        pump_en = 1'b1;
        if (abort) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_unit = 1'b1;
          if ((r_fuel + WIDTH'(1)) == r_target) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fill datapath: latch on acceptance, meter units during PUMP, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_fuel    <= '0;
      r_deliv   <= '0;
      r_target  <= '0;
      r_capped  <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_fuel    <= tank_level;
      r_deliv   <= '0;
      r_target  <= w_target;
      r_capped  <= w_capped;
      r_aborted <= 1'b0;
    end else if (r_state == S_PUMP) begin
      if (abort) begin
        r_cnt     <= '0;
        r_aborted <= 1'b1;
      end else if (w_unit) begin
        r_cnt   <= '0;
        r_fuel  <= r_fuel + WIDTH'(1);
        r_deliv <= r_deliv + WIDTH'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign fuel_level = r_fuel;
  assign delivered  = r_deliv;
  assign capped     = r_capped;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_fuel_refill_controller.sv
// Directed bench for fuel_refill_controller with hand-computed expectations.
module tb_fuel_refill_controller;

  logic       clk;
  logic       reset;
  logic [4:0] tank_level;
  logic       req_valid;
  logic [4:0] req_amount;
  logic       abort;
  logic       req_ready;
  logic       pump_en;
  logic [4:0] fuel_level;
  logic [4:0] delivered;
  logic       done;
  logic       capped;
  logic       aborted;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fuel_refill_controller #(
    .WIDTH   (5),
    .CAPACITY(31),
    .PUMP_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tank_level(tank_level),
    .req_valid (req_valid),
    .req_amount(req_amount),
    .abort     (abort),
    .req_ready (req_ready),
    .pump_en   (pump_en),
    .fuel_level(fuel_level),
    .delivered (delivered),
    .done      (done),
    .capped    (capped),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept a request in the current IDLE cycle; returns in cycle T+1.
  task automatic accept(input logic [4:0] t, input logic [4:0] a);
    tank_level = t;
    req_amount = a;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  // Full fill of n units expected; checks every PUMP cycle, the done cycle
  // and the following IDLE cycle.
  task automatic fill(input string tag, input logic [4:0] t, input logic [4:0] a,
                      input int unsigned n, input logic cap);
    logic [4:0] exp_lvl;
    accept(t, a);
    for (int unsigned k = 1; k <= n * 4; k++) begin
      exp_lvl = t + 5'((k - 1) / 4);
      chk({tag, "_pump_en"}, pump_en, 1'b1);
      chk({tag, "_lvl_run"}, fuel_level, exp_lvl);
      step();
    end
    exp_lvl = t + 5'(n);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_pump_off"}, pump_en, 1'b0);
    chk({tag, "_ready_done"}, req_ready, 1'b0);
    chk({tag, "_fuel"}, fuel_level, exp_lvl);
    chk({tag, "_delivered"}, delivered, 5'(n));
    chk({tag, "_capped"}, capped, cap);
    chk({tag, "_aborted"}, aborted, 1'b0);
    step();
    chk({tag, "_ready_idle"}, req_ready, 1'b1);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_fuel_hold"}, fuel_level, exp_lvl);
  endtask

  initial begin
    reset      = 1'b1;
    tank_level = '0;
    req_valid  = 1'b0;
    req_amount = '0;
    abort      = 1'b0;
    step();
    step();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_pump", pump_en, 1'b0);
    chk("rst_fuel", fuel_level, 5'd0);
    chk("rst_deliv", delivered, 5'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_capped", capped, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    reset = 1'b0;
    step();

    // 5 + 3: 12 pump cycles, levels 6/7/8
    fill("f5p3", 5'd5, 5'd3, 3, 1'b0);
    // 28 + 10 capped at 31
    fill("f28p10", 5'd28, 5'd10, 3, 1'b1);
    // already full
    fill("f31p4", 5'd31, 5'd4, 0, 1'b1);
    // zero amount
    fill("f10p0", 5'd10, 5'd0, 0, 1'b0);

    // abort coinciding with the second unit's completion (cycle T+8)
    accept(5'd0, 5'd5);
    repeat (7) step();
    abort = 1'b1;
    chk("ab_pump", pump_en, 1'b1);
    chk("ab_lvl_before", fuel_level, 5'd1);
    step();
    abort = 1'b0;
    chk("ab_done", done, 1'b1);
    chk("ab_deliv", delivered, 5'd1);
    chk("ab_fuel", fuel_level, 5'd1);
    chk("ab_aborted", aborted, 1'b1);
    step();
    chk("ab_ready", req_ready, 1'b1);
    chk("ab_hold", aborted, 1'b1);

    // back-to-back with req_valid held high
    tank_level = 5'd3;
    req_amount = 5'd1;
    req_valid  = 1'b1;
    for (int unsigned f = 0; f < 2; f++) begin
      chk("b2b_ready_idle", req_ready, 1'b1);
      step();
      for (int unsigned k = 0; k < 4; k++) begin
        chk("b2b_ready_pump", req_ready, 1'b0);
        chk("b2b_pump_en", pump_en, 1'b1);
        step();
      end
      chk("b2b_ready_done", req_ready, 1'b0);
      chk("b2b_done", done, 1'b1);
      chk("b2b_deliv", delivered, 5'd1);
      chk("b2b_fuel", fuel_level, 5'd4);
      step();
    end
    req_valid = 1'b0;
    step();

    // reset in the middle of a fill discards it
    accept(5'd2, 5'd5);
    repeat (5) step();
    chk("mid_pump", pump_en, 1'b1);
    req_valid = 1'b1;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 1'b0;
    chk("mrst_ready", req_ready, 1'b1);
    chk("mrst_pump", pump_en, 1'b0);
    chk("mrst_fuel", fuel_level, 5'd0);
    chk("mrst_deliv", delivered, 5'd0);
    chk("mrst_done", done, 1'b0);
    step();
    chk("mrst_idle_pump", pump_en, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
